// File: rtl/session_timer_pkg.sv
// Shared types and constants for the session countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/session_timer_if.sv
// Control/status bundle between the session timer and its controller.
interface session_timer_if #(
    parameter int unsigned TICK_W = 8
);
    logic              slow_clk;
    logic              start;
    logic              kick;
    logic              cancel;
    logic [TICK_W-1:0] load_val;
    logic              tick;
    logic              busy;
    logic [TICK_W-1:0] remaining;
    logic              expired;

    modport master (
        output slow_clk, start, kick, cancel, load_val,
        input  tick, busy, remaining, expired
    );

    modport slave (
        input  slow_clk, start, kick, cancel, load_val,
        output tick, busy, remaining, expired
    );
endinterface

// File: rtl/session_timer_tick_edge_detect.sv
// Synchronizes the divided slow wave into clk and emits one tick per rising edge.
module tick_edge_detect
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic slow_clk,
    output logic tick
);
    localparam int unsigned STAGES =
        (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              prev_q;
    logic              armed_q;
    logic              edge_q;
    logic              tick_q;
    logic              synced;
    logic              raw_edge;

    assign synced   = sync_q[STAGES-1];
    assign raw_edge = synced & ~prev_q;
    assign tick     = tick_q;

    // fill_q marks when synced reflects real input rather than reset zeros,
    // so a wave already high at release cannot arm the detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], slow_clk};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
            prev_q <= synced;
            if (fill_q[STAGES-1] && !synced) begin
                armed_q <= 1'b1;
            end
            edge_q <= raw_edge & armed_q;
            tick_q <= edge_q;
        end
    end
endmodule

// File: rtl/session_timer.sv
// Session/keypad timeout: counts slow-wave ticks down from a loaded value and pulses expiry.
module session_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            reset,
    session_timer_if.slave bus
);
    logic              tick;
    state_e            state_q, state_d;
    logic [TICK_W-1:0] remaining_q, remaining_d;

    tick_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk     (clk),
        .reset   (reset),
        .slow_clk(bus.slow_clk),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.load_val != '0) begin
                        state_d     = RUN;
                        remaining_d = bus.load_val;
                    end else begin
                        state_d     = EXPIRE;
                        remaining_d = '0;
                    end
                end
            end
            RUN: begin
                // Reload outranks a same-cycle tick; that tick is dropped.
                if (bus.cancel) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (bus.start || bus.kick) begin
                    if (bus.load_val != '0) begin
                        remaining_d = bus.load_val;
                    end else begin
                        state_d     = EXPIRE;
                        remaining_d = '0;
                    end
                end else if (tick) begin
                    if (remaining_q <= TICK_W'(1)) begin
                        state_d     = EXPIRE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - TICK_W'(1);
                    end
                end
            end
            EXPIRE: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

    assign bus.tick      = tick;
    assign bus.busy      = (state_q == RUN);
    assign bus.remaining = remaining_q;
    assign bus.expired   = (state_q == EXPIRE);
endmodule

// File: tb/tb_session_timer.sv
// Directed scenario bench for session_timer with a free-running 16-cycle slow wave.
module tb_session_timer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   wave_ph  = 0;
    bit   wave_en  = 1'b0;

    session_timer_if #(.TICK_W(8)) bus();

    session_timer #(
        .TICK_W     (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; the slow wave is 8 cycles low, 8 high.
    task automatic step();
        @(negedge clk);
        if (wave_en) begin
            wave_ph      = (wave_ph + 1) % 16;
            bus.slow_clk = (wave_ph >= 8);
        end
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_wait_tick got=no tick exp=tick within 40 cycles", tag);
        end
    endtask

    task automatic test_reset();
        int ticks;
        int n;
        reset = 1'b1;
        bus.slow_clk = 1'b1;
        bus.start = 1'b0; bus.kick = 1'b0; bus.cancel = 1'b0; bus.load_val = '0;
        repeat (3) step();
        reset = 1'b0;
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", bus.tick); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.remaining !== 8'd0) begin failures++; $display("FAIL reset_remaining got=%0d exp=0", bus.remaining); end
        checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%0b exp=0", bus.expired); end
        ticks = 0;
        repeat (20) begin
            step();
            if (bus.tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 0) begin failures++; $display("FAIL no_spurious_tick got=%0d exp=0", ticks); end
        wave_ph = 0;
        bus.slow_clk = 1'b0;
        wave_en = 1'b1;
        n = 0;
        while (bus.slow_clk !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.tick !== (i == 4)) begin
                failures++;
                $display("FAIL tick_latency_edge%0d got=%0b exp=%0b", i, bus.tick, (i == 4));
            end
        end
        step();
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%0b exp=0", bus.tick); end
        ticks = 0;
        repeat (64) begin
            step();
            if (bus.tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 4) begin failures++; $display("FAIL ticks_per_period got=%0d exp=4", ticks); end
    endtask

    task automatic test_basic_expiry();
        bus.load_val = 8'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", bus.busy); end
        checks++; if (bus.remaining !== 8'd3) begin failures++; $display("FAIL start_remaining got=%0d exp=3", bus.remaining); end
        for (int k = 0; k < 3; k++) begin
            wait_tick("expiry");
            checks++;
            if (bus.remaining !== 8'(3 - k)) begin
                failures++; $display("FAIL expiry_rem_at_tick%0d got=%0d exp=%0d", k, bus.remaining, 3 - k);
            end
            step();
            if (k < 2) begin
                checks++;
                if (bus.remaining !== 8'(2 - k) || bus.busy !== 1'b1) begin
                    failures++; $display("FAIL expiry_dec%0d got=rem %0d busy %0b exp=rem %0d busy 1", k, bus.remaining, bus.busy, 2 - k);
                end
            end else begin
                checks++; if (bus.expired !== 1'b1) begin failures++; $display("FAIL expiry_pulse got=%0b exp=1", bus.expired); end
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL expiry_busy got=%0b exp=0", bus.busy); end
                checks++; if (bus.remaining !== 8'd0) begin failures++; $display("FAIL expiry_remaining got=%0d exp=0", bus.remaining); end
            end
        end
        step();
        checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL expiry_width got=%0b exp=0", bus.expired); end
    endtask

    task automatic test_kick_collision();
        bus.load_val = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_tick("kick");
        checks++; if (bus.remaining !== 8'd2) begin failures++; $display("FAIL kick_pre_rem got=%0d exp=2", bus.remaining); end
        bus.kick = 1'b1;
        bus.load_val = 8'd5;
        step();
        bus.kick = 1'b0;
        checks++; if (bus.remaining !== 8'd5) begin failures++; $display("FAIL kick_reload got=%0d exp=5", bus.remaining); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL kick_busy got=%0b exp=1", bus.busy); end
        for (int k = 0; k < 5; k++) begin
            wait_tick("kick_run");
            step();
            checks++;
            if (k < 4) begin
                if (bus.remaining !== 8'(4 - k)) begin
                    failures++; $display("FAIL kick_dec%0d got=%0d exp=%0d", k, bus.remaining, 4 - k);
                end
            end else if (bus.expired !== 1'b1) begin
                failures++; $display("FAIL kick_expiry got=%0b exp=1", bus.expired);
            end
        end
        step();
    endtask

    task automatic test_cancel_vs_expiry();
        int pulses;
        bus.load_val = 8'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_tick("cancel");
        checks++; if (bus.remaining !== 8'd1) begin failures++; $display("FAIL cancel_pre_rem got=%0d exp=1", bus.remaining); end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.remaining !== 8'd0) begin failures++; $display("FAIL cancel_remaining got=%0d exp=0", bus.remaining); end
        pulses = (bus.expired === 1'b1) ? 1 : 0;
        repeat (20) begin
            step();
            if (bus.expired === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL cancel_no_expiry got=%0d exp=0", pulses); end
    endtask

    task automatic test_zero_load();
        bus.load_val = 8'd5;
        bus.kick = 1'b1;
        step();
        bus.kick = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL kick_in_idle got=%0b exp=0", bus.busy); end
        bus.load_val = 8'd0;
        bus.start = 1'b1;
        step();
        checks++; if (bus.expired !== 1'b1) begin failures++; $display("FAIL zero_expired got=%0b exp=1", bus.expired); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b exp=0", bus.busy); end
        bus.load_val = 8'd3;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_in_expire got=%0b exp=0", bus.busy); end
        checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL zero_width got=%0b exp=0", bus.expired); end
        step();
    endtask

    task automatic test_reset_mid_run();
        int bad;
        bus.load_val = 8'd6;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_tick("midrun");
        step();
        wait_tick("midrun");
        step();
        checks++;
        if (bus.remaining !== 8'd4 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL midrun_pre got=rem %0d busy %0b exp=rem 4 busy 1", bus.remaining, bus.busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL midrun_tick got=%0b exp=0", bus.tick); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrun_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.remaining !== 8'd0) begin failures++; $display("FAIL midrun_remaining got=%0d exp=0", bus.remaining); end
        checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL midrun_expired got=%0b exp=0", bus.expired); end
        bad = 0;
        repeat (40) begin
            step();
            if (bus.expired === 1'b1 || bus.busy === 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midrun_quiet got=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic_expiry();
        test_kick_collision();
        test_cancel_vs_expiry();
        test_zero_load();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/session_timer.md
# session_timer

Countdown timer that consumes the slow square-wave clock produced by the design's clock divider, turning each rising edge into a single-cycle tick in the `clk` domain. It counts those ticks down from a loaded value and flags expiry. The bank/ATM control logic uses it for session and keypad-entry timeouts. It is the receiving end of the divider output: the divider generates the slow wave, this block detects its edges and acts on them.

## Interface
- `TICK_W`, default 8: width of the load value and remaining count.
- `SYNC_STAGES`, default 2: synchronizer flops on `slow_clk` (minimum 2).
- `clk`, input, 1: system clock; the only clock in the block.
- `reset`, input, 1: synchronous, active-high reset.
- `slow_clk`, input, 1: divided square wave, treated as data, never used as a clock.
- `start`, input, 1: load `load_val` and begin counting.
- `kick`, input, 1: reload `load_val` while running; ignored in IDLE.
- `cancel`, input, 1: abort the count without flagging expiry.
- `load_val`, input, TICK_W: number of ticks until expiry, sampled on `start`/`kick`.
- `tick`, output, 1: one-cycle pulse per detected rising edge of `slow_clk`.
- `busy`, output, 1: high while in RUN.
- `remaining`, output, TICK_W: ticks left; 0 outside RUN.
- `expired`, output, 1: one-cycle pulse when the count reaches 0.

## Operation
- Edge path:
  - `slow_clk` passes through SYNC_STAGES flops, then a `prev` flop.
  - Raw edge = synced & ~prev; it is registered to form `tick`.
- Arm flag:
  - Cleared by reset; set the first cycle synced `slow_clk` is 0.
  - `tick` is suppressed while the flag is clear, so a wave that is high at reset release gives no spurious tick.
- States:
  - IDLE: `busy`=0, `remaining`=0.
  - `start` with `load_val`≠0 → RUN, `remaining`=`load_val`.
  - `start` with `load_val`=0 → EXPIRE.
  - RUN, in priority order:
    1. `cancel` → IDLE, `remaining`=0.
    2. else `start` or `kick` → reload `remaining`=`load_val` and stay in RUN; a `load_val`=0 reload goes to EXPIRE.
    3. else `tick` with `remaining`=1 → EXPIRE, `remaining`=0.
    4. else `tick` → `remaining`-1.
  - EXPIRE: lasts exactly one cycle, `expired`=1, `busy`=0, then IDLE. `start` is ignored in that cycle.
- Simultaneous events:
  - `cancel` beats everything.
  - A reload beats a tick in the same cycle; that tick is discarded, not deferred.
- `remaining` never underflows. Decrement happens only from values ≥2; the value 1 goes to 0 via EXPIRE.
- `tick` keeps running in every state; it is independent of the FSM.

## Timing
- Reset values: `tick`=0, `busy`=0, `remaining`=0, `expired`=0, state=IDLE. All sync flops, `prev` and the arm flag are 0.
- Reset mid-RUN: the next cycle is IDLE with all outputs 0 and no `expired` pulse.
- `tick` latency:
  - Goes high SYNC_STAGES+2 `clk` edges after the first edge that samples `slow_clk` high.
  - That is 4 edges at the default.
  - Width is exactly 1 cycle.
- `start`/`kick` take effect at the next edge: `busy` and `remaining` update in the following cycle.
- The decrement happens at the edge where `tick`=1, so `remaining` changes one cycle after the `tick` pulse is visible.
- `expired` goes high one cycle after the final `tick` is seen, and stays high 1 cycle.
- `busy` falls in the same cycle `expired` rises.
- Minimum `slow_clk` high and low time is SYNC_STAGES+1 `clk` cycles. Shorter pulses may be missed; this is not an error.

## Structure
- `timer_pkg` holds:
  - the state typedef (IDLE, RUN, EXPIRE, 2-bit encoding);
  - `SYNC_STAGES_MIN`=2.
- Sub-module `tick_edge_detect` holds the synchronizer, `prev`, the arm flag and the registered `tick`. Ports: `clk`, `reset`, `slow_clk`, `tick`.
- `session_timer` instantiates `tick_edge_detect` and contains the FSM and the down-counter.

## Test plan
- **Reset with wave high:** hold `slow_clk`=1 through reset release for 20 cycles, then a normal wave.
  - No `tick` until the first 0→1 transition after the release.
  - Then one `tick` per period.
- **Basic expiry:**
  - Set `slow_clk` period to 16 cycles (8 high, 8 low). Issue `start` with `load_val`=3.
  - `remaining` goes 3→2→1→0 on successive ticks.
  - `expired` pulses once, one cycle after the 3rd `tick`, with `busy` low in that cycle.
- **Kick collision:** `load_val`=5 and `kick` in the same cycle as a `tick`, with `remaining`=2.
  - `remaining` becomes 5, not 4 or 1.
  - Expiry comes 5 ticks later.
- **Cancel vs. expiry:** `cancel` asserted in the same cycle as a `tick` with `remaining`=1.
  - The FSM goes to IDLE.
  - `expired` never pulses.
- **Zero load:** `start` with `load_val`=0.
  - `expired` pulses in the next cycle.
  - `busy` never rises.
- **Reset mid-run:** assert `reset` with `remaining`=4 and `busy`=1.
  - Next cycle: all outputs 0, state IDLE.
  - No `expired` pulse follows.
